// File: rtl/basic_saboteur_pkg.sv
// Shared definitions for the basic_saboteur fault-injection block:
// fault-mode encodings and the default counter width.
package basic_saboteur_pkg;

  localparam logic [1:0] MODE_SA0   = 2'b00;
  localparam logic [1:0] MODE_SA1   = 2'b01;
  localparam logic [1:0] MODE_FLIP  = 2'b10;
  localparam logic [1:0] MODE_TRANS = 2'b11;

  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/basic_saboteur_timer.sv
// Down-counter for the transient flip window: load has priority over clear,
// otherwise it counts down to zero and stops. nonzero reports a live window.
module basic_saboteur_timer
  import basic_saboteur_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             clear,
  output logic             nonzero
);

  logic [CNT_W-1:0] count_q;

  // Timer register: load, clear, or decrement while non-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (clear) begin
      count_q <= '0;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign nonzero = |count_q;

endmodule

// File: rtl/basic_saboteur.sv
// Single-bit saboteur in series with one datapath signal. Passes i_bit when
// disabled, otherwise applies stuck-at-0/1, permanent flip or a timed
// transient flip. Counts enable rises (saturating) for campaign bookkeeping.
// Optional feature macro: BASIC_SABOTEUR_TRANSIENT_EN. When undefined no timer
// is built and mode 11 behaves as a permanent flip.
module basic_saboteur
  import basic_saboteur_pkg::*;
#(
  parameter int TRANSIENT_CYCLES = 1,
  parameter int CNT_W            = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_bit,
  input  logic             i_en,
  input  logic [1:0]       i_ctrl,
  output logic             o_fault,
  output logic             o_active,
  output logic [CNT_W-1:0] o_inj_cnt
);

  // Reject an out-of-range flip length at elaboration.
  if (TRANSIENT_CYCLES < 1 || TRANSIENT_CYCLES > (1 << CNT_W) - 1) begin : g_bad_tc
    $error("basic_saboteur: TRANSIENT_CYCLES out of range");
  end

  logic             en_q;
  logic             rise;
  logic [CNT_W-1:0] cnt_q;
  logic             window;

  assign rise = i_en & ~en_q;

  // Enable history for rise detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_q <= 1'b0;
    end else begin
      en_q <= i_en;
    end
  end

  // Injection event counter: one count per enable rise, stops at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (rise && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_inj_cnt = cnt_q;

`ifdef BASIC_SABOTEUR_TRANSIENT_EN
  logic trans_sel;
  logic timer_nonzero;

  // The window is only ever open while enabled in mode 11; anything else
  // closes it immediately and clears the timer on the next edge.
  assign trans_sel = i_en && (i_ctrl == MODE_TRANS);

  basic_saboteur_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .load    (rise && trans_sel),
    .load_val(CNT_W'(TRANSIENT_CYCLES - 1)),
    .clear   (!trans_sel),
    .nonzero (timer_nonzero)
  );

  // The rise cycle itself is the first flipped cycle; the timer covers the rest.
  assign window = trans_sel && (rise || timer_nonzero);
`else
  // Without the timer, mode 11 is a permanent flip.
  assign window = 1'b1;
`endif

  // Fault application: reset and disable both give pass-through.
  always_comb begin
    o_fault  = i_bit;
    o_active = 1'b0;
    if (i_rst_n && i_en) begin
      case (i_ctrl)
        MODE_SA0: begin
          o_fault  = 1'b0;
          o_active = 1'b1;
        end
        MODE_SA1: begin
          o_fault  = 1'b1;
          o_active = 1'b1;
        end
        MODE_FLIP: begin
          o_fault  = ~i_bit;
          o_active = 1'b1;
        end
        default: begin
          if (window) begin
            o_fault  = ~i_bit;
            o_active = 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_basic_saboteur.sv
// Bench for basic_saboteur (TRANSIENT_CYCLES = 3, CNT_W = 4). Inputs change on
// the falling edge; a reference model judges every cycle, and a directed
// prologue pins the model with hand-computed values before random traffic.
module tb_basic_saboteur;

  localparam int TC      = 3;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef BASIC_SABOTEUR_TRANSIENT_EN
  localparam bit TRANS_ON = 1'b1;
`else
  localparam bit TRANS_ON = 1'b0;
`endif

  // clock / reset
  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          bit_in;
  logic [1:0]    ctrl;
  logic          fault;
  logic          active;
  logic [CW-1:0] inj_cnt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  basic_saboteur #(
    .TRANSIENT_CYCLES(TC),
    .CNT_W           (CW)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_bit    (bit_in),
    .i_en     (en),
    .i_ctrl   (ctrl),
    .o_fault  (fault),
    .o_active (active),
    .o_inj_cnt(inj_cnt)
  );

  // scoreboard: expected counter value for each coming cycle
  logic [CW-1:0] exp_q[$];

  // model state: last sampled enable, the cycle of the last transient-arming
  // rise, and whether enable/mode 11 has held without a break since then
  bit m_prev_en  = 1'b0;
  bit m_armed    = 1'b0;
  int m_rise_cyc = 0;
  int m_cyc      = 0;
  int m_cnt      = 0;

  initial exp_q.push_back('0);

  // compare process: evaluate the model for this cycle, check, then advance
  always @(negedge clk) begin
    bit            rise;
    bit            win;
    logic          ef;
    logic          ea;
    logic [CW-1:0] ec;
    #2;
    rise = en && !m_prev_en;
    win  = TRANS_ON && en && (ctrl == 2'b11) &&
           (rise || (m_armed && (m_cyc - m_rise_cyc) < TC));
    if (!rst_n || !en) begin
      ef = bit_in;
      ea = 1'b0;
    end else begin
      case (ctrl)
        2'b00:   begin ef = 1'b0;    ea = 1'b1; end
        2'b01:   begin ef = 1'b1;    ea = 1'b1; end
        2'b10:   begin ef = ~bit_in; ea = 1'b1; end
        default: begin
          if (!TRANS_ON) begin
            ef = ~bit_in;
            ea = 1'b1;
          end else begin
            ef = win ? ~bit_in : bit_in;
            ea = win;
          end
        end
      endcase
    end
    ec = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    if (!rst_n) ec = '0;
    vectors++;
    if (fault !== ef) begin
      miscompares++;
      $display("FAIL o_fault cycle %0d: got %b expected %b", m_cyc, fault, ef);
    end
    if (active !== ea) begin
      miscompares++;
      $display("FAIL o_active cycle %0d: got %b expected %b", m_cyc, active, ea);
    end
    if (inj_cnt !== ec) begin
      miscompares++;
      $display("FAIL o_inj_cnt cycle %0d: got %0d expected %0d", m_cyc, inj_cnt, ec);
    end
    // advance model across the coming rising edge
    if (!rst_n) begin
      m_prev_en = 1'b0;
      m_armed   = 1'b0;
      m_cnt     = 0;
    end else begin
      if (rise && m_cnt < CNT_MAX) m_cnt++;
      if (rise && ctrl == 2'b11) begin
        m_armed    = 1'b1;
        m_rise_cyc = m_cyc;
      end else if (!(en && ctrl == 2'b11)) begin
        m_armed = 1'b0;
      end
      m_prev_en = en;
    end
    exp_q.push_back(CW'(m_cnt));
    m_cyc++;
  end

  // driver tasks
  task automatic step(input logic r, input logic e, input logic [1:0] c, input logic b);
    @(negedge clk);
    rst_n  = r;
    en     = e;
    ctrl   = c;
    bit_in = b;
    #3;
  endtask

  task automatic expect_lit(input string name, input logic f, input logic a, input int cnt);
    if (fault !== f || active !== a || inj_cnt !== CW'(cnt)) begin
      miscompares++;
      $display("FAIL %s: got fault=%b active=%b cnt=%0d expected fault=%b active=%b cnt=%0d",
               name, fault, active, inj_cnt, f, a, cnt);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    ctrl   = 2'b00;
    bit_in = 1'b0;

    step(0, 0, 2'b00, 1); expect_lit("reset", 1, 0, 0);
    step(1, 0, 2'b00, 0); expect_lit("pass0", 0, 0, 0);
    step(1, 0, 2'b01, 1); expect_lit("pass1", 1, 0, 0);
    step(1, 1, 2'b00, 1); expect_lit("sa0_b1", 0, 1, 0);
    step(1, 1, 2'b01, 1); expect_lit("sa1_b1", 1, 1, 1);
    step(1, 1, 2'b10, 1); expect_lit("flip_b1", 0, 1, 1);
    step(1, 1, 2'b01, 0); expect_lit("sa1_b0", 1, 1, 1);
    step(1, 1, 2'b10, 0); expect_lit("flip_b0", 1, 1, 1);
    step(1, 0, 2'b11, 0); expect_lit("idle", 0, 0, 1);

    for (int i = 0; i < 4; i++) begin
      step(1, 1, 2'b11, 0);
      expect_lit("trans_a", TRANS_ON ? (i < 3) : 1'b1, TRANS_ON ? (i < 3) : 1'b1, (i == 0) ? 1 : 2);
    end
    step(1, 0, 2'b11, 0); expect_lit("trans_gap", 0, 0, 2);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 2'b11, 0);
      expect_lit("trans_b", 1, 1, (i == 0) ? 2 : 3);
    end
    step(1, 0, 2'b11, 0); expect_lit("trans_end", 0, 0, 3);

    // abort by dropping enable, then by leaving mode 11
    step(1, 1, 2'b11, 1); expect_lit("abort_a0", 0, 1, 3);
    step(1, 1, 2'b11, 1); expect_lit("abort_a1", 0, 1, 4);
    step(1, 0, 2'b11, 1); expect_lit("abort_en", 1, 0, 4);
    step(1, 1, 2'b11, 1); expect_lit("abort_b0", 0, 1, 4);
    step(1, 1, 2'b00, 1); expect_lit("abort_b1", 0, 1, 5);
    step(1, 1, 2'b11, 1); expect_lit("abort_ctrl", TRANS_ON ? 1'b1 : 1'b0, TRANS_ON ? 1'b0 : 1'b1, 5);

    // reset in the middle of an injection
    step(1, 0, 2'b00, 1); expect_lit("pre_rst", 1, 0, 5);
    step(1, 1, 2'b11, 1); expect_lit("rst_trans", 0, 1, 5);
    step(0, 1, 2'b00, 1); expect_lit("in_rst", 1, 0, 0);
    step(1, 1, 2'b00, 1); expect_lit("rst_rel", 0, 1, 0);
    step(1, 1, 2'b00, 1); expect_lit("rst_cnt", 0, 1, 1);

    // saturation
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 2'b10, 0);
      step(1, 1, 2'b10, 0);
    end
    step(1, 1, 2'b10, 0); expect_lit("saturate", 1, 1, 15);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      logic       r;
      logic       e;
      logic [1:0] c;
      r = ($urandom_range(0, 99) != 0);
      e = ($urandom_range(0, 99) < 30) ? ~en : en;
      c = ctrl;
      if ($urandom_range(0, 99) < 15) c = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
      step(r, e, c, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
